// File: rtl/data_memory.sv
// data_memory: block-wide backing store on the responder side of the
// cache-to-memory interface. Each read or write takes LATENCY busy cycles,
// then one DONE cycle. Addresses wrap modulo the storage depth.
module data_memory #(
    parameter int LATENCY    = 5,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         mem_Read,
    input  logic         mem_Write,
    input  logic [27:0]  mem_Address,
    input  logic [127:0] mem_Writedata,
    output logic [127:0] mem_Readdata,
    output logic         mem_BusyWait
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  is_write_q, is_write_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [127:0]          wdata_q, wdata_d;
    logic [127:0]          rdata_q, rdata_d;
    logic [127:0]          mem [DEPTH];

    logic accept;
    logic last_busy;
    logic commit_wr;

    // Upper address bits are deliberately ignored so that addresses alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_Address[27:DEPTH_LOG2];

    // Only IDLE accepts; a request still held in DONE is ignored until IDLE.
    assign accept    = (state_q == IDLE) && (mem_Read || mem_Write);
    assign last_busy = (state_q == BUSY) && (cnt_q == 4'd0);
    assign commit_wr = last_busy && is_write_q && !RESET;

    // Next-state, counter and latched-operand computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = BUSY;
                    cnt_d      = 4'(LATENCY - 1);
                    // Write wins when both requests are raised together.
                    is_write_d = mem_Write;
                    addr_d     = mem_Address[DEPTH_LOG2-1:0];
                    wdata_d    = mem_Writedata;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (!is_write_q) begin
                        rdata_d = mem[addr_q];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and read-data register; reset wins over every transition.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
        end
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Storage array: never cleared, written only when a write completes.
    always_ff @(posedge CLK) begin
        if (commit_wr) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign mem_Readdata = rdata_q;
    assign mem_BusyWait = !RESET &&
                          ((state_q == BUSY) ||
                           ((state_q == IDLE) && (mem_Read || mem_Write)));

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter LATENCY, default 5, number of BUSY cycles per access (legal range 1..15).
REQ-002 Parameter DEPTH_LOG2, default 8, log2 of the number of 128-bit blocks stored.
REQ-003 CLK  input  1  single clock; all state updates occur on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 mem_Read  input  1  block read request, level-held by the requester until mem_BusyWait is low.
REQ-006 mem_Write  input  1  block write request, level-held by the requester until mem_BusyWait is low.
REQ-007 mem_Address  input  28  block address (byte address [31:4]).
REQ-008 mem_Writedata  input  128  block write data; byte 0 is in bits [7:0].
REQ-009 mem_Readdata  output  128  block read data, registered.
REQ-010 mem_BusyWait  output  1  stall to requester; low means the access has completed or no access is pending.

Function
REQ-011 The block SHALL act as the responder end of the cache-to-memory block interface, serving both reads and writes (write-back of dirty data-cache lines).
REQ-012 Storage SHALL be 2^DEPTH_LOG2 entries x 128 bits, indexed by mem_Address[DEPTH_LOG2-1:0], with upper address bits ignored so that addresses alias modulo depth.
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 In IDLE, with mem_Read or mem_Write high at a clock edge, the block SHALL latch address, write data and operation, load the counter with LATENCY-1, and enter BUSY.
REQ-015 When mem_Read and mem_Write are both high in IDLE, the access SHALL be performed as a write, and mem_Readdata SHALL remain unchanged.
REQ-016 In BUSY with counter > 0, each edge SHALL decrement the counter.
REQ-017 In BUSY with counter = 0, the edge SHALL perform the latched access and enter DONE. A read loads mem_Readdata from the array; a write updates the array entry.
REQ-018 In DONE, the next edge SHALL return the FSM to IDLE unconditionally. A request still high in DONE SHALL NOT start an access.
REQ-019 mem_BusyWait SHALL equal (state = BUSY) OR (state = IDLE AND (mem_Read OR mem_Write)); it is combinational from the request only in IDLE.
REQ-020 Latency: busywait SHALL be high for exactly LATENCY+1 cycles (request cycle plus LATENCY BUSY cycles), then low in DONE.
REQ-021 With LATENCY = 5, the response SHALL appear 6 cycles after the request.
REQ-022 mem_Readdata SHALL be valid from the DONE cycle onward and SHALL hold its value until the next completed read.
REQ-023 Changes to mem_Address, mem_Writedata or the request signals during BUSY SHALL have no effect on the access in progress.
REQ-024 Dropping the request during BUSY SHALL NOT abort the access; it completes and commits normally.
REQ-025 Back-to-back accesses SHALL be separated by at least one IDLE cycle, giving a throughput of one access per LATENCY+2 cycles.

Reset
REQ-026 RESET high at an edge SHALL force state to IDLE, counter to 0 and mem_Readdata to 128'h0.
REQ-027 mem_BusyWait SHALL be 0 while RESET is high, regardless of the request inputs.
REQ-028 RESET during BUSY SHALL abort the access with no array write committed.
REQ-029 Array contents SHALL NOT be modified by RESET.
REQ-030 RESET SHALL take priority over every state transition in the same edge.

Verification
REQ-031 Write then read: write addr 28'h0000010, data 128'hDEADBEEF_01234567_89ABCDEF_CAFEBABE, then read addr 28'h0000010 -> busywait high 6 cycles for each access; mem_Readdata equals the written data in the read's DONE cycle.
REQ-032 Aliasing: write 128'h1 to addr 28'h0000005, then read addr 28'h0000105 (DEPTH_LOG2 = 8) -> mem_Readdata = 128'h1.
REQ-033 Simultaneous request: mem_Read = mem_Write = 1, data 128'hAA to addr 3 -> array[3] = 128'hAA and mem_Readdata unchanged; a subsequent read of addr 3 returns 128'hAA.
REQ-034 Reset mid-operation: write 128'hFF to addr 7 with RESET pulsed on the 3rd BUSY cycle -> busywait 0 while RESET is high; a later read of addr 7 returns the prior contents, not 128'hFF.
REQ-035 Input churn: change mem_Address and mem_Writedata every cycle during BUSY -> only the values latched at acceptance are written.
REQ-036 Held request and parameter sweep: request held high through DONE -> exactly one IDLE cycle, then re-acceptance with busywait high again; with LATENCY = 1, busywait is high for exactly 2 cycles.
